serial_dot_product_engine: RTL and testbench

//   Parametrised successor of the fixed 8x8-bit serial dot-product macro.

---
 rtl/serial_dot_product_engine.sv | 136 +++++++++++++
 tb/tb_serial_dot_product_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_dot_product_engine.sv
// Bit-serial dot-product engine: receives A0,B0,A1,B1,... LSB first on one
// line and accumulates sum(A[i]*B[i]) exactly, then reports a truncated
// result with an overflow flag.
//
// Handshake: Start is accepted only in IDLE or DONE (Busy low); a Start seen
// while Busy is ignored. Done is a one-cycle pulse marking DataOut/Ovf valid;
// both then hold until the next Done or reset. There is no back-pressure.
module serial_dot_product_engine #(
    parameter int DATA_W      = 8,
    parameter int VEC_LEN     = 8,
    parameter int ACC_W       = 2*DATA_W + $clog2(VEC_LEN),
    parameter int SIGNED_MODE = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             SerialData,
    output logic [ACC_W-1:0] DataOut,
    output logic             Done,
    output logic             Busy,
    output logic             Ovf,
    output logic [1:0]       dbg_state
);

    localparam int FULL_W = 2*DATA_W + $clog2(VEC_LEN) + 1;
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int ELEM_W = $clog2(VEC_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    state_t              state, state_nx;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ELEM_W-1:0]   elem_cnt;
    logic                is_b;
    logic [DATA_W-2:0]   sh;
    logic [DATA_W-1:0]   a_reg, b_reg, new_elem;
    logic                mac_pend;
    logic [FULL_W-1:0]   acc, a_ext, b_ext, prod, sum;
    logic [ACC_W-1:0]    result;
    logic                ovf_c;
    logic                last_bit, last_elem, accept;

    assign new_elem  = {SerialData, sh};
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W-1));
    assign last_elem = last_bit && is_b && (elem_cnt == ELEM_W'(VEC_LEN-1));
    assign accept    = Start && (state == IDLE || state == DONE);

    // Operand extension to the exact width; the product is exact modulo 2^FULL_W.
    assign a_ext = (SIGNED_MODE != 0) ? FULL_W'($signed(a_reg)) : FULL_W'(a_reg);
    assign b_ext = (SIGNED_MODE != 0) ? FULL_W'($signed(b_reg)) : FULL_W'(b_reg);
    assign prod  = a_ext * b_ext;
    assign sum   = acc + (mac_pend ? prod : '0);

    generate
        if (ACC_W < FULL_W) begin : g_trunc
            assign result = sum[ACC_W-1:0];
            if (SIGNED_MODE != 0) begin : g_sovf
                assign ovf_c = (sum[FULL_W-1:ACC_W-1] != {(FULL_W-ACC_W+1){sum[ACC_W-1]}});
            end else begin : g_uovf
                assign ovf_c = |sum[FULL_W-1:ACC_W];
            end
        end else begin : g_wide
            assign result = (SIGNED_MODE != 0) ? ACC_W'($signed(sum)) : ACC_W'(sum);
            assign ovf_c  = 1'b0;
        end
    endgenerate

    assign Done      = (state == DONE);
    assign Busy      = (state == LOAD) || (state == FLUSH);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Start) state_nx = LOAD;
            LOAD:    if (last_elem) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = Start ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Deserialiser, counters and multiply-accumulate; each pair's MAC runs
    // one cycle after its B MSB, overlapping reception of the next A.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            bit_cnt  <= '0;
            elem_cnt <= '0;
            is_b     <= 1'b0;
            sh       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            mac_pend <= 1'b0;
            acc      <= '0;
            DataOut  <= '0;
            Ovf      <= 1'b0;
        end else if (accept) begin
            bit_cnt  <= '0;
            elem_cnt <= '0;
            is_b     <= 1'b0;
            mac_pend <= 1'b0;
            acc      <= '0;
        end else if (state == LOAD) begin
            sh      <= new_elem[DATA_W-1:1];
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (mac_pend) begin
                acc      <= sum;
                mac_pend <= 1'b0;
            end
            if (last_bit) begin
                if (is_b) begin
                    b_reg    <= new_elem;
                    mac_pend <= 1'b1;
                    is_b     <= 1'b0;
                    elem_cnt <= (elem_cnt == ELEM_W'(VEC_LEN-1)) ? '0 : elem_cnt + 1'b1;
                end else begin
                    a_reg <= new_elem;
                    is_b  <= 1'b1;
                end
            end
        end else if (state == FLUSH) begin
            acc      <= sum;
            mac_pend <= 1'b0;
            DataOut  <= result;
            Ovf      <= ovf_c;
        end
    end

endmodule

// File: tb/tb_serial_dot_product_engine.sv
// Directed bench for serial_dot_product_engine: three instances share the
// input stream (unsigned default, signed, unsigned with ACC_W=16).
module tb_serial_dot_product_engine;

    logic        clk = 1'b0;
    logic        reset_n, start, serial_data;
    logic [18:0] dout_u, dout_s;
    logic [15:0] dout_n;
    logic        done_u, done_s, done_n;
    logic        busy_u, busy_s, busy_n;
    logic        ovf_u, ovf_s, ovf_n;
    logic [1:0]  st_u, st_s, st_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] va [8];
    logic [7:0] vb [8];
    int done_at, done_cnt, busy_err;

    serial_dot_product_engine u_dut (
        .clk(clk), .Reset(reset_n), .Start(start), .SerialData(serial_data),
        .DataOut(dout_u), .Done(done_u), .Busy(busy_u), .Ovf(ovf_u), .dbg_state(st_u));

    serial_dot_product_engine #(.SIGNED_MODE(1)) s_dut (
        .clk(clk), .Reset(reset_n), .Start(start), .SerialData(serial_data),
        .DataOut(dout_s), .Done(done_s), .Busy(busy_s), .Ovf(ovf_s), .dbg_state(st_s));

    serial_dot_product_engine #(.ACC_W(16)) n_dut (
        .clk(clk), .Reset(reset_n), .Start(start), .SerialData(serial_data),
        .DataOut(dout_n), .Done(done_n), .Busy(busy_n), .Ovf(ovf_n), .dbg_state(st_n));

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic stream_bit(input int j);
        int e;
        int b;
        logic [7:0] el;
        e  = j / 8;
        b  = j % 8;
        el = (e % 2 == 1) ? vb[e/2] : va[e/2];
        return el[b];
    endfunction

    task automatic fill(input logic [7:0] a0, input logic [7:0] b0, input int a_ramp, input int b_ramp);
        for (int i = 0; i < 8; i++) begin
            va[i] = a0 + 8'(a_ramp * i);
            vb[i] = b0 + 8'(b_ramp * i);
        end
    endtask

    // Drives one operation; Start accepted at edge 0, observations taken at
    // the falling edge before edge k ("cycle k").
    task automatic run_op(input bit started, input bit chain, input int r1, input int r2);
        done_at  = -1;
        done_cnt = 0;
        busy_err = 0;
        if (!started) begin
            @(negedge clk);
            start       = 1'b1;
            serial_data = 1'b0;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 131; cyc++) begin
            @(negedge clk);
            serial_data = (cyc <= 128) ? stream_bit(cyc - 1) : 1'b0;
            start       = (cyc == r1) || (cyc == r2) || (chain && cyc == 130);
            if (done_u) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (busy_u !== (cyc <= 129)) busy_err++;
            if (chain && cyc == 130) break;
        end
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_done_cycle"}, done_at, 130);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_window"}, busy_err, 0);
    endtask

    task automatic check_results(input string tag,
                                 input logic [31:0] eu, input logic eou,
                                 input logic [31:0] es, input logic eos,
                                 input logic [31:0] en, input logic eon);
        check({tag, "_u_data"}, 32'(dout_u), eu);
        check({tag, "_u_ovf"},  32'(ovf_u),  32'(eou));
        check({tag, "_s_data"}, 32'(dout_s), es);
        check({tag, "_s_ovf"},  32'(ovf_s),  32'(eos));
        check({tag, "_n_data"}, 32'(dout_n), en);
        check({tag, "_n_ovf"},  32'(ovf_n),  32'(eon));
    endtask

    initial begin
        int errs;
        reset_n     = 1'b0;
        start       = 1'b0;
        serial_data = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", 32'(dout_u), 32'd0);
        check("reset_done", 32'(done_u), 32'd0);
        check("reset_busy", 32'(busy_u), 32'd0);
        check("reset_ovf",  32'(ovf_u),  32'd0);
        check("reset_state", 32'(st_u), 32'd0);
        reset_n = 1'b1;

        // All 0xFF: unsigned 8*255*255 = 520200; signed 8*(-1*-1) = 8;
        // 16-bit unsigned 520200 mod 65536 = 61448 with overflow.
        fill(8'hFF, 8'hFF, 0, 0);
        run_op(0, 0, 0, 0);
        check_timing("ff");
        check_results("ff", 32'd520200, 1'b0, 32'd8, 1'b0, 32'd61448, 1'b1);

        // Reset mid-LOAD: everything returns to reset values, no Done afterwards.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            serial_data = 1'($urandom_range(0, 1));
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy_u), 32'd0);
        check("rst_mid_dout", 32'(dout_u), 32'd0);
        check("rst_mid_state", 32'(st_s), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            serial_data = 1'($urandom_range(0, 1));
            if (done_u || done_s || done_n || busy_u || busy_s || busy_n) errs++;
            if (ovf_u || ovf_s || ovf_n) errs++;
            if (dout_u != 0 || dout_s != 0 || dout_n != 0) errs++;
        end
        check("rst_idle_quiet", errs, 0);

        // All 0x80: unsigned 8*128*128 = 131072; signed (-128)^2*8 = 131072;
        // 16-bit: 131072 mod 65536 = 0 with overflow.
        fill(8'h80, 8'h80, 0, 0);
        run_op(0, 0, 0, 0);
        check_timing("m80");
        check_results("m80", 32'd131072, 1'b0, 32'd131072, 1'b0, 32'd0, 1'b1);

        // A=0x80, B=0x7F: unsigned 8*128*127 = 130048; signed -130048 = 19'h60400;
        // 16-bit: 130048 - 65536 = 64512 with overflow.
        fill(8'h80, 8'h7F, 0, 0);
        run_op(0, 0, 0, 0);
        check_timing("m7f");
        check_results("m7f", 32'd130048, 1'b0, 32'h60400, 1'b0, 32'd64512, 1'b1);

        // A=1..8, B=8..1 with Start re-pulsed while Busy: sum = 120, one Done.
        fill(8'd1, 8'd8, 1, -1);
        run_op(0, 0, 5, 60);
        check_timing("ramp");
        check_results("ramp", 32'd120, 1'b0, 32'd120, 1'b0, 32'd120, 1'b0);

        // Back-to-back: A=1..8,B=2 -> 72; then A=3,B=1..8 -> 108, Start in Done cycle.
        fill(8'd1, 8'd2, 1, 0);
        run_op(0, 1, 0, 0);
        check_timing("b2b_first");
        check_results("b2b_first", 32'd72, 1'b0, 32'd72, 1'b0, 32'd72, 1'b0);
        fill(8'd3, 8'd1, 0, 1);
        run_op(1, 0, 0, 0);
        check_timing("b2b_second");
        check_results("b2b_second", 32'd108, 1'b0, 32'd108, 1'b0, 32'd108, 1'b0);

        // Result holds after Done while idle and SerialData toggles.
        repeat (5) begin
            @(negedge clk);
            serial_data = 1'($urandom_range(0, 1));
        end
        check("hold_dout", 32'(dout_u), 32'd108);
        check("hold_idle", 32'(st_u), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
